auto_hc_mask: RTL and testbench
===============================

# auto_hc_mask

Parametrised input-conditioning stage for the anode trigger path. It sits between the raw layer hit inputs and the pulse extender, pattern finder and shower detector. Each cycle it registers the layer hits, gated by the input-disable and test-injection controls, and masked by both the static hot-channel mask and an automatically learned mask. Each enabled channel has a leading-edge hit counter over a programmable window. A channel whose count reaches threshold is auto-masked, and stays masked until cleared.

## Interface
Parameters:
- NLY, 6, number of layers
- NW, 48, wire groups per layer
- CW, 8, per-channel hit counter width (saturating)
- WW, 16, window counter width
- NAW, $clog2(NLY*NW+1), width of auto-masked channel count

Ports (NCH = NLY*NW; channel index = layer*NW + wire):
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- ly_in  input  NCH  raw layer hits
- hc_mask  input  NCH  static mask, 1 = channel enabled
- input_disr  input  1  1 = force all outputs to 0, no counting
- gate_inputs  input  1  1 = test-pulse/ext-trigger blanking; same effect as input_disr
- auto_en  input  1  enable hit counting and window evaluation
- window_len  input  WW  window length in clocks; 0 = monitoring idle
- hot_thresh  input  CW  edge count that marks a channel hot; 0 = never mark
- clear_auto  input  1  single-cycle pulse: clear the auto mask and restart the window
- ly_out  output  NCH  registered masked hits
- auto_mask  output  NCH  1 = channel auto-masked
- n_auto  output  NAW  number of set auto_mask bits
- window_done  output  1  one-cycle pulse after each window evaluation

## Operation
- Block enable: blk = input_disr | gate_inputs.
- Output register: ly_out <= blk ? 0 : ly_in & hc_mask & ~auto_mask.
- Edge detect:
  - prev <= blk ? 0 : ly_in.
  - edge[i] = ly_in[i] & ~prev[i] & hc_mask[i] & ~auto_mask[i] & ~blk.
  - A held-high input counts as one edge.
- Monitoring active: act = auto_en & (window_len != 0).
- Counters when act = 0:
  - win_cnt and all hit counters are held at 0.
  - auto_mask keeps its value.
- Counters when act = 1:
  - Each cycle, cnt[i] <= min(cnt[i] + edge[i], 2^CW - 1). The counter saturates and never wraps.
- Terminal cycle: the cycle where win_cnt >= window_len - 1. The >= test makes a window_len reduced mid-window end immediately.
  - For each i, cnt_next[i] is the saturated count including this cycle's edge.
  - If hot_thresh != 0 and cnt_next[i] >= hot_thresh, auto_mask[i] <= 1. The mask is sticky.
  - All cnt <= 0, win_cnt <= 0, window_done <= 1.
- Otherwise win_cnt <= win_cnt + 1 and window_done <= 0.
- clear_auto:
  - auto_mask <= 0, all cnt <= 0, win_cnt <= 0, window_done <= 0.
  - It has priority over a simultaneous terminal cycle: no new mask bits are set and no done pulse is issued.
- n_auto <= popcount(auto_mask), registered from the current auto_mask.

## Timing
- Reset values (asynchronous, all 0): ly_out, auto_mask, n_auto, window_done, prev, win_cnt, all cnt.
- ly_in to ly_out: 1 clock.
- Terminal cycle T:
  - auto_mask and window_done are updated at edge T+1.
  - ly_out reflects the new mask from the cycle after that (register at edge T+2).
  - n_auto is updated at edge T+2.
- Windows are back-to-back. With constant window_len = L, window_done pulses every L clocks.
- Reset asserted mid-window discards the partial window. Counting restarts from win_cnt = 0 after deassertion.
- Static mask and gating changes take effect on ly_out one clock later.

## Test plan
- Reset and pass-through:
  - Stimulus: assert rst mid-run, then hc_mask = all 1s, ly_in = 0x…A5.
  - Response: after rst, all outputs are 0. ly_out = ly_in delayed 1 clock. Clearing hc_mask[3] forces ly_out[3] = 0.
- Hot channel:
  - Stimulus: auto_en = 1, window_len = 10, hot_thresh = 3. Channel 5 toggles 1/0 each clock (5 edges per window). Channel 7 is held at 1.
  - Response: after window 1, auto_mask[5] = 1, auto_mask[7] = 0, window_done pulses once, n_auto = 1. From then on ly_out[5] = 0.
- Gating:
  - Stimulus: input_disr = 1 (and separately gate_inputs = 1) while channel 5 toggles, window_len = 10, hot_thresh = 3.
  - Response: ly_out = 0 and no mask is set after 3 windows.
- Saturation and threshold 0:
  - Stimulus: CW = 4, 40 edges on channel 2, window_len = 100, hot_thresh = 15.
  - Response: auto_mask[2] = 1 (no wrap to 8).
  - Stimulus: repeat with hot_thresh = 0.
  - Response: no bits set.
- clear_auto priority:
  - Stimulus: clear_auto coincident with the terminal cycle of a window in which channel 9 is hot.
  - Response: auto_mask stays 0, no window_done pulse, and the next window_done arrives window_len clocks later.
- Window shrink and disable:
  - Stimulus: at win_cnt = 20, change window_len from 50 to 10.
  - Response: window_done pulses on the next clock.
  - Stimulus: auto_en = 0 afterwards.
  - Response: win_cnt stays 0, auto_mask is retained, and n_auto is unchanged.

Source files
------------

// File: rtl/auto_hc_mask.sv
// auto_hc_mask: input conditioning for the anode trigger path.
// Registers layer hits gated by the disable/blanking controls and masked by the
// static hot-channel mask plus a self-learned auto mask. Each channel counts
// leading edges over a programmable window. A channel reaching threshold is
// auto-masked until clear_auto.
module auto_hc_mask #(
  parameter int NLY = 6,
  parameter int NW  = 48,
  parameter int CW  = 8,
  parameter int WW  = 16,
  parameter int NAW = $clog2(NLY*NW+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NLY*NW-1:0]    ly_in,
  input  logic [NLY*NW-1:0]    hc_mask,
  input  logic                 input_disr,
  input  logic                 gate_inputs,
  input  logic                 auto_en,
  input  logic [WW-1:0]        window_len,
  input  logic [CW-1:0]        hot_thresh,
  input  logic                 clear_auto,
  output logic [NLY*NW-1:0]    ly_out,
  output logic [NLY*NW-1:0]    auto_mask,
  output logic [NAW-1:0]       n_auto,
  output logic                 window_done
);

  localparam int NCH = NLY*NW;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [WW-1:0] WIN_ONE = {{(WW-1){1'b0}}, 1'b1};

  logic           blk;
  logic           act;
  logic           term;
  logic [NCH-1:0] edge_det;
  logic [NCH-1:0] hot_set;
  logic [NCH-1:0] ly_out_q, ly_out_d;
  logic [NCH-1:0] prev_q, prev_d;
  logic [NCH-1:0] auto_mask_q, auto_mask_d;
  logic [WW-1:0]  win_cnt_q, win_cnt_d;
  logic [NAW-1:0] n_auto_q, n_auto_d;
  logic           done_q, done_d;

  // Blanking kills both the output and the edge history, so the first hit
  // after blanking ends is seen as a fresh leading edge.
  assign blk      = input_disr | gate_inputs;
  assign act      = auto_en & (window_len != '0);
  // >= rather than == so that shrinking window_len mid-window ends it at once.
  assign term     = act & (win_cnt_q >= (window_len - WIN_ONE));
  assign edge_det = ly_in & ~prev_q & hc_mask & ~auto_mask_q & {NCH{~blk}};
  assign ly_out_d = blk ? '0 : (ly_in & hc_mask & ~auto_mask_q);
  assign prev_d   = blk ? '0 : ly_in;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d, cnt_sat;

      // Saturating add: a very hot channel must not wrap below threshold.
      assign cnt_sat     = (cnt_q == CNT_MAX) ? cnt_q
                                              : cnt_q + {{(CW-1){1'b0}}, edge_det[gi]};
      // Threshold test uses the count including this terminal cycle's edge.
      assign hot_set[gi] = term & (hot_thresh != '0) & (cnt_sat >= hot_thresh);
      assign cnt_d       = (clear_auto | ~act | term) ? '0 : cnt_sat;

      // Per-channel edge counter, restarted at window end, on clear or when idle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end
  endgenerate

  // clear_auto wins over a coincident terminal cycle: no new bits, no pulse.
  assign win_cnt_d   = (clear_auto | ~act | term) ? '0 : win_cnt_q + WIN_ONE;
  assign auto_mask_d = clear_auto ? '0 : (auto_mask_q | hot_set);
  assign done_d      = term & ~clear_auto;

  // Population count of the current auto mask
  always_comb begin
    n_auto_d = '0;
    for (int i = 0; i < NCH; i++) begin
      n_auto_d = n_auto_d + {{(NAW-1){1'b0}}, auto_mask_q[i]};
    end
  end

  // Output, edge history, window and mask state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ly_out_q    <= '0;
      prev_q      <= '0;
      auto_mask_q <= '0;
      win_cnt_q   <= '0;
      n_auto_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      ly_out_q    <= ly_out_d;
      prev_q      <= prev_d;
      auto_mask_q <= auto_mask_d;
      win_cnt_q   <= win_cnt_d;
      n_auto_q    <= n_auto_d;
      done_q      <= done_d;
    end
  end

  assign ly_out      = ly_out_q;
  assign auto_mask   = auto_mask_q;
  assign n_auto      = n_auto_q;
  assign window_done = done_q;

endmodule

// File: tb/tb_auto_hc_mask.sv
// tb_auto_hc_mask: table vectors for pass-through/gating, directed sequences
// for the windowed auto-mask corner cases, and randomized traffic, all checked
// every cycle against a channel-level reference model.
module tb_auto_hc_mask;

  localparam int NLY  = 6;
  localparam int NW   = 48;
  localparam int CW   = 4;
  localparam int WW   = 16;
  localparam int NCH  = NLY*NW;
  localparam int NAW  = $clog2(NCH+1);
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] ly_in, hc;
  logic           dis, gate, auto_en, clear;
  logic [WW-1:0]  wl;
  logic [CW-1:0]  thr;
  logic [NCH-1:0] ly_out, auto_mask;
  logic [NAW-1:0] n_auto;
  logic           window_done;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  auto_hc_mask #(.NLY(NLY), .NW(NW), .CW(CW), .WW(WW), .NAW(NAW)) dut (
    .clk(clk), .rst(rst), .ly_in(ly_in), .hc_mask(hc),
    .input_disr(dis), .gate_inputs(gate), .auto_en(auto_en),
    .window_len(wl), .hot_thresh(thr), .clear_auto(clear),
    .ly_out(ly_out), .auto_mask(auto_mask), .n_auto(n_auto),
    .window_done(window_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [NCH-1:0] m_prev, m_mask, m_out;
  int           m_cnt [NCH];
  int           m_win;
  int           m_nauto;
  bit           m_done;

  task automatic model_step();
    bit [NCH-1:0] new_mask;
    bit           e [NCH];
    bit           blk;
    int           c;
    if (rst) begin
      m_prev = '0; m_mask = '0; m_out = '0; m_win = 0; m_nauto = 0; m_done = 0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      return;
    end
    blk = dis | gate;
    for (int i = 0; i < NCH; i++)
      e[i] = ly_in[i] && !m_prev[i] && hc[i] && !m_mask[i] && !blk;
    new_mask = m_mask;
    m_nauto  = $countones(m_mask);
    m_out    = blk ? '0 : (ly_in & hc & ~m_mask);
    if (clear) begin
      new_mask = '0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_win = 0; m_done = 0;
    end else if (!(auto_en && wl != 0)) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_win = 0; m_done = 0;
    end else if (m_win >= int'(wl) - 1) begin
      for (int i = 0; i < NCH; i++) begin
        c = m_cnt[i] + (e[i] ? 1 : 0);
        if (c > CMAX) c = CMAX;
        if (thr != 0 && c >= int'(thr)) new_mask[i] = 1'b1;
        m_cnt[i] = 0;
      end
      m_win = 0; m_done = 1;
      $display("cycle %0d: window done, %0d channels auto-masked", cyc, $countones(new_mask));
    end else begin
      for (int i = 0; i < NCH; i++) begin
        c = m_cnt[i] + (e[i] ? 1 : 0);
        m_cnt[i] = (c > CMAX) ? CMAX : c;
      end
      m_win++; m_done = 0;
    end
    m_prev = blk ? '0 : ly_in;
    m_mask = new_mask;
  endtask

  task automatic chk(input string name, input logic [NCH-1:0] act_v, input logic [NCH-1:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("model_ly_out", ly_out, m_out);
    chk("model_auto_mask", auto_mask, m_mask);
    chk("model_n_auto", NCH'(n_auto), NCH'(m_nauto));
    chk("model_done", NCH'(window_done), NCH'(m_done));
  endtask

  task automatic clear_state();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic           rst;
    logic           dis;
    logic           gate;
    logic [NCH-1:0] hc;
    logic [NCH-1:0] din;
    logic [NCH-1:0] exp_out;
  } vec_t;

  vec_t           vt [8];
  logic [NCH-1:0] pat, ones, b3, b5, b7, b2, b9, b11;

  initial begin
    pat  = {36{8'hA5}};
    ones = '1;
    b2 = NCH'(1) << 2;  b3 = NCH'(1) << 3;  b5 = NCH'(1) << 5;
    b7 = NCH'(1) << 7;  b9 = NCH'(1) << 9;  b11 = NCH'(1) << 11;
    vt[0] = '{1'b1, 1'b0, 1'b0, ones,       pat,  '0};
    vt[1] = '{1'b0, 1'b0, 1'b0, ones,       pat,  pat};
    vt[2] = '{1'b0, 1'b0, 1'b0, ones & ~b3, ones, ones & ~b3};
    vt[3] = '{1'b0, 1'b1, 1'b0, ones,       ~pat, '0};
    vt[4] = '{1'b0, 1'b0, 1'b1, ones,       ~pat, '0};
    vt[5] = '{1'b0, 1'b0, 1'b0, ones,       ~pat, ~pat};
    vt[6] = '{1'b0, 1'b0, 1'b0, ones,       '0,   '0};
    vt[7] = '{1'b0, 1'b0, 1'b0, '0,         ones, '0};

    rst = 1'b1; ly_in = '0; hc = '1; dis = 0; gate = 0; auto_en = 0;
    clear = 0; wl = '0; thr = '0;
    tick(); tick();
    chk("reset_ly_out", ly_out, '0);
    chk("reset_mask", auto_mask, '0);
    rst = 1'b0;

    // Hot channel: ch5 toggles (5 edges/window), ch7 held high (1 edge)
    auto_en = 1; wl = 10; thr = 3;
    for (int t = 1; t <= 10; t++) begin
      ly_in = (t % 2 == 1) ? (b5 | b7) : b7;
      tick();
      if (t < 10) chk("hot_no_early_done", NCH'(window_done), '0);
    end
    chk("hot_mask5", NCH'(auto_mask[5]), NCH'(1));
    chk("hot_mask7", NCH'(auto_mask[7]), '0);
    chk("hot_done", NCH'(window_done), NCH'(1));
    ly_in = b5 | b7;
    tick();
    chk("hot_n_auto", NCH'(n_auto), NCH'(1));
    chk("hot_done_once", NCH'(window_done), '0);
    chk("hot_ly_out5_masked", NCH'(ly_out[5]), '0);
    chk("hot_ly_out7_live", NCH'(ly_out[7]), NCH'(1));
    $display("hot channel sequence: auto_mask[5]=%0b n_auto=%0d", auto_mask[5], n_auto);

    // Table: reset mid-run, pass-through, static mask, gating
    auto_en = 0;
    for (int k = 0; k < 8; k++) begin
      rst = vt[k].rst; dis = vt[k].dis; gate = vt[k].gate;
      hc = vt[k].hc; ly_in = vt[k].din;
      tick();
      chk($sformatf("table%0d_ly_out", k), ly_out, vt[k].exp_out);
      if (vt[k].rst) begin
        chk("table_rst_mask", auto_mask, '0);
        chk("table_rst_n_auto", NCH'(n_auto), '0);
      end
      $display("vector %0d: rst=%0b dis=%0b gate=%0b ly_out[7:0]=%h", k, vt[k].rst,
               vt[k].dis, vt[k].gate, ly_out[7:0]);
    end
    rst = 0; dis = 0; gate = 0; hc = '1;

    // Gating: input_disr, then gate_inputs, each over 3 windows
    for (int g = 0; g < 2; g++) begin
      auto_en = 1; wl = 10; thr = 3;
      dis = (g == 0); gate = (g == 1);
      for (int t = 1; t <= 30; t++) begin
        ly_in = (t % 2 == 1) ? b5 : '0;
        tick();
      end
      chk($sformatf("gate%0d_ly_out", g), ly_out, '0);
      chk($sformatf("gate%0d_mask", g), auto_mask, '0);
      $display("gating sequence %0d: auto_mask empty=%0b", g, auto_mask == '0);
    end
    dis = 0; gate = 0;

    // Saturation (40 edges, CW=4, thresh 15) and threshold 0
    for (int s = 0; s < 2; s++) begin
      wl = 100; thr = (s == 0) ? 4'd15 : 4'd0;
      ly_in = '0;
      clear_state();
      for (int t = 1; t <= 100; t++) begin
        ly_in = (t <= 80 && t % 2 == 1) ? b2 : '0;
        tick();
      end
      chk($sformatf("sat%0d_done", s), NCH'(window_done), NCH'(1));
      chk($sformatf("sat%0d_mask", s), auto_mask, (s == 0) ? b2 : '0);
      $display("saturation sequence thresh=%0d: auto_mask[2]=%0b", thr, auto_mask[2]);
    end

    // clear_auto coincident with the terminal cycle
    wl = 10; thr = 3; ly_in = '0;
    clear_state();
    for (int t = 1; t <= 10; t++) begin
      ly_in = (t % 2 == 1) ? b9 : '0;
      clear = (t == 10);
      tick();
    end
    clear = 0;
    chk("clrpri_mask", auto_mask, '0);
    chk("clrpri_done", NCH'(window_done), '0);
    ly_in = '0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("clrpri_next_done", NCH'(window_done), NCH'(t == 10));
    end
    $display("clear priority sequence: auto_mask empty=%0b", auto_mask == '0);

    // Window shrink mid-window, then disable
    wl = 50; thr = 3; ly_in = '0;
    clear_state();
    for (int t = 1; t <= 20; t++) begin
      ly_in = (t % 2 == 1) ? b11 : '0;
      tick();
      chk("shrink_no_done", NCH'(window_done), '0);
    end
    wl = 10; ly_in = '0;
    tick();
    chk("shrink_done", NCH'(window_done), NCH'(1));
    chk("shrink_mask11", auto_mask, b11);
    auto_en = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk("disable_no_done", NCH'(window_done), '0);
    end
    chk("disable_mask_kept", auto_mask, b11);
    chk("disable_n_auto", NCH'(n_auto), NCH'(1));
    $display("shrink/disable sequence: n_auto=%0d", n_auto);

    // Randomized traffic against the model
    auto_en = 1; wl = 7; thr = 2;
    clear_state();
    for (int r = 0; r < 3000; r++) begin
      for (int w = 0; w < NCH/32; w++) ly_in[w*32 +: 32] = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 49) == 0)
        for (int w = 0; w < NCH/32; w++) hc[w*32 +: 32] = $urandom | $urandom;
      dis   = ($urandom_range(0, 19) == 0);
      gate  = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 149) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 199) == 0) wl = WW'($urandom_range(0, 25));
      if ($urandom_range(0, 199) == 0) thr = CW'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
